// File: rtl/mmio_pkg.sv
// Register offsets, STATUS bit positions and the TX FSM state type
// shared by the memory-mapped UART blocks.
package mmio_pkg;

    localparam logic [1:0] TXDATA_OFS  = 2'b00;
    localparam logic [1:0] STATUS_OFS  = 2'b01;
    localparam logic [1:0] BAUDDIV_OFS = 2'b10;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A pop and a push in the same
// cycle on a full FIFO both succeed, leaving the count unchanged.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so wrap is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the dmem-style port: FIFO-buffered,
// programmable bit period of BAUDDIV+1 clocks, 1-cycle registered read data.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 433,
    parameter int DIV_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [3:0]  wea,
    input  logic [31:0] addra,
    input  logic [31:0] dina,
    output logic [31:0] douta,
    output logic        txd,
    output logic        irq_tx_empty
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       ofs;
    logic             wr;
    logic             rd;
    logic             push_req;
    logic             pop_req;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [DIV_W-1:0] bauddiv;
    logic             overflow;
    logic [31:0]      div_old;
    logic [31:0]      div_new;
    logic [31:0]      status;
    logic [31:0]      rdata;

    tx_state_t        state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_lat;
    logic [7:0]       shift;
    logic [2:0]       bit_cnt;
    logic             bit_end;

    logic             unused_bits;
    assign unused_bits = ^{addra[31:4], addra[1:0], div_new[31:DIV_W]};

    assign ofs      = addra[3:2];
    assign wr       = ena && (wea != 4'b0000);
    assign rd       = ena && (wea == 4'b0000);
    assign push_req = wr && (ofs == TXDATA_OFS) && wea[0];
    assign bit_end  = (cnt == '0);
    assign pop_req  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

    assign irq_tx_empty = fifo_empty && (state == IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop_req),
        .din   (dina[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        div_old = 32'(bauddiv);
        div_new = div_old;
        for (int b = 0; b < 4; b++) begin
            if (wea[b]) begin
                div_new[b*8 +: 8] = dina[b*8 +: 8];
            end
        end
    end

    always_comb begin
        status                     = '0;
        status[ST_BUSY]            = (state != IDLE);
        status[ST_FULL]            = fifo_full;
        status[ST_EMPTY]           = fifo_empty;
        status[ST_OVF]             = overflow;
        status[ST_CNT_LSB +: CW]   = fifo_count;
    end

    always_comb begin
        rdata = '0;
        case (ofs)
            STATUS_OFS:  rdata = status;
            BAUDDIV_OFS: rdata = div_old;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            douta    <= '0;
            bauddiv  <= DIV_W'(DEFAULT_DIV);
            overflow <= 1'b0;
        end else begin
            if (rd) begin
                douta <= rdata;
            end
            if (wr && (ofs == BAUDDIV_OFS)) begin
                bauddiv <= div_new[DIV_W-1:0];
            end
            // A pop in the same cycle frees a slot, so only a true full drops.
            if (push_req && fifo_full && !pop_req) begin
                overflow <= 1'b1;
            end else if (wr && (ofs == STATUS_OFS) && wea[0] && dina[ST_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    // txd is registered one state ahead: the value for the next bit is
    // loaded at the boundary that enters it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            div_lat <= '0;
            shift   <= '0;
            bit_cnt <= '0;
            txd     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift   <= fifo_dout;
                        div_lat <= bauddiv;
                        cnt     <= bauddiv;
                        bit_cnt <= '0;
                        txd     <= 1'b0;
                        state   <= START;
                    end else begin
                        txd <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt   <= div_lat;
                        txd   <= shift[0];
                        shift <= shift >> 1;
                        state <= DATA;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= div_lat;
                        if (bit_cnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            txd     <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (!fifo_empty) begin
                            shift   <= fifo_dout;
                            div_lat <= bauddiv;
                            cnt     <= bauddiv;
                            bit_cnt <= '0;
                            txd     <= 1'b0;
                            state   <= START;
                        end else begin
                            txd   <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed and randomized bench for mmio_uart_tx; txd/irq are logged every
// cycle and frames are compared against the expected 8N1 bit sequence.
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [3:0]  wea;
    logic [31:0] addra;
    logic [31:0] dina;
    logic [31:0] douta;
    logic        txd;
    logic        irq_tx_empty;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] A_TX  = 32'h0;
    localparam logic [31:0] A_ST  = 32'h4;
    localparam logic [31:0] A_DIV = 32'h8;
    localparam logic [31:0] A_RES = 32'hC;

    typedef struct packed {
        logic t;
        logic irq;
    } samp_t;

    samp_t log_q[$];
    bit    log_en = 1'b0;

    mmio_uart_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .wea          (wea),
        .addra        (addra),
        .dina         (dina),
        .douta        (douta),
        .txd          (txd),
        .irq_tx_empty (irq_tx_empty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (log_en) log_q.push_back('{t: txd, irq: irq_tx_empty});
    end

    function automatic logic [31:0] st(input bit busy, input bit full, input bit empty,
                                       input bit ovf, input int cnt);
        logic [31:0] w;
        w = 32'(cnt) << 8;
        w[0] = busy;
        w[1] = full;
        w[2] = empty;
        w[3] = ovf;
        return w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        ena = 1'b1; wea = we; addra = a; dina = d;
        @(negedge clk);
        ena = 1'b0; wea = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        ena = 1'b1; wea = 4'b0000; addra = a;
        @(negedge clk);
        d = douta;
        ena = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic start_log();
        log_en = 1'b0;
        log_q.delete();
        log_en = 1'b1;
    endtask

    task automatic next_sample(output samp_t s);
        int guard = 0;
        while (log_q.size() == 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (log_q.size() == 0) s = 2'bxx;
        else s = log_q.pop_front();
    endtask

    // Expected line: start 0, data LSB first, stop 1; each bit div+1 cycles, irq low throughout.
    task automatic check_frame(input logic [7:0] d, input int div, input int max_gap, input string tag);
        samp_t s;
        int gap = 0;
        int errs = 0;
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        next_sample(s);
        while (s.t === 1'b1 && gap < max_gap) begin
            gap++;
            next_sample(s);
        end
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c <= div; c++) begin
                if (k != 0 || c != 0) next_sample(s);
                if (s.t !== bits[k] || s.irq !== 1'b0) errs++;
            end
        end
        check(tag, errs, 0);
    endtask

    task automatic check_idle(input int n, input string tag);
        samp_t s;
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            next_sample(s);
            if (s.t !== 1'b1 || s.irq !== 1'b1) errs++;
        end
        check(tag, errs, 0);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] d;
        int guard = 0;
        bus_read(A_ST, d);
        while (d !== st(0, 0, 1, 0, 0) && guard < 20000) begin
            bus_read(A_ST, d);
            guard++;
        end
        check(tag, d, st(0, 0, 1, 0, 0));
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [31:0] d;
        logic [15:0] r16;
        int          div;
        int          n;

        rst_n = 1'b0; ena = 1'b0; wea = 4'b0000; addra = '0; dina = '0;
        repeat (2) @(negedge clk);
        check("rst_txd", 32'(txd), 1);
        check("rst_irq", 32'(irq_tx_empty), 1);
        check("rst_douta", douta, 0);
        rst_n = 1'b1;
        @(negedge clk);
        read_check("rst_status", A_ST, st(0, 0, 1, 0, 0));
        read_check("rst_div", A_DIV, 433);
        read_check("txdata_reads0", A_TX, 0);
        read_check("reserved_reads0", A_RES, 0);

        // Single frame
        bus_write(A_DIV, 4'b0011, 3);
        start_log();
        bus_write(A_TX, 4'b0001, 32'hA5);
        repeat (2) @(negedge clk);
        read_check("single_busy", A_ST, st(1, 0, 1, 0, 0));
        check_frame(8'hA5, 3, 50, "single_frame");
        check_idle(3, "single_idle");
        wait_idle("single_done");

        // Back-to-back
        bus_write(A_DIV, 4'b0011, 1);
        start_log();
        bus_write(A_TX, 4'b0001, 32'h00);
        bus_write(A_TX, 4'b0001, 32'hFF);
        bus_write(A_TX, 4'b0001, 32'h55);
        read_check("b2b_count2", A_ST, st(1, 0, 0, 0, 2));
        check_frame(8'h00, 1, 50, "b2b_f0");
        check_frame(8'hFF, 1, 0, "b2b_f1");
        check_frame(8'h55, 1, 0, "b2b_f2");
        check_idle(4, "b2b_idle");
        wait_idle("b2b_done");

        // Overflow: one byte popped immediately, eight fill the FIFO, the tenth is dropped
        bus_write(A_DIV, 4'b0011, 100);
        q.delete();
        start_log();
        for (int i = 0; i < 10; i++) begin
            q.push_back(8'($urandom));
            bus_write(A_TX, 4'b0001, 32'(q[i]));
        end
        read_check("ovf_status", A_ST, st(1, 1, 0, 1, 8));
        bus_write(A_ST, 4'b0001, 32'h8);
        read_check("ovf_cleared", A_ST, st(1, 1, 0, 0, 8));
        for (int i = 0; i < 9; i++) begin
            check_frame(q[i], 100, (i == 0) ? 50 : 0, $sformatf("ovf_f%0d", i));
        end
        check_idle(20, "ovf_only9");
        wait_idle("ovf_done");

        // Bus timing
        start_log();
        read_check("bt_div", A_DIV, 100);
        ena = 1'b1; wea = 4'b0000; addra = A_ST;
        #1 check("bt_pre_edge", douta, 100);
        @(negedge clk);
        check("bt_edge", douta, st(0, 0, 1, 0, 0));
        ena = 1'b0; addra = A_DIV;
        @(negedge clk);
        check("bt_hold1", douta, st(0, 0, 1, 0, 0));
        @(negedge clk);
        check("bt_hold2", douta, st(0, 0, 1, 0, 0));
        bus_write(A_TX, 4'b0010, 32'h0000_7777);
        check("bt_hold_write", douta, st(0, 0, 1, 0, 0));
        read_check("bt_no_push", A_ST, st(0, 0, 1, 0, 0));
        check_idle(5, "bt_idle");

        // BAUDDIV byte lanes
        bus_write(A_DIV, 4'b1111, 32'hFFFF_FFFF);
        read_check("div_upper0", A_DIV, 32'h0000_FFFF);
        bus_write(A_DIV, 4'b0001, 32'h1234_5678);
        read_check("div_byte0", A_DIV, 32'h0000_FF78);
        bus_write(A_DIV, 4'b0010, 32'hAAAA_BBCC);
        read_check("div_byte1", A_DIV, 32'h0000_BB78);
        r16 = 16'($urandom);
        bus_write(A_DIV, 4'b0011, 32'(r16));
        read_check("div_rand", A_DIV, 32'(r16));

        // Mid-frame divisor change
        bus_write(A_DIV, 4'b0011, 3);
        start_log();
        bus_write(A_TX, 4'b0001, 32'h3C);
        bus_write(A_TX, 4'b0001, 32'hC1);
        repeat (6) @(negedge clk);
        bus_write(A_DIV, 4'b0011, 7);
        check_frame(8'h3C, 3, 50, "mid_f0");
        check_frame(8'hC1, 7, 0, "mid_f1");
        check_idle(4, "mid_idle");
        wait_idle("mid_done");

        // Randomized bursts; the first uses the minimum 1-cycle bit period
        for (int it = 0; it < 5; it++) begin
            div = (it == 0) ? 0 : int'($urandom_range(0, 6));
            n = int'($urandom_range(1, 4));
            bus_write(A_DIV, 4'b0011, 32'(div));
            q.delete();
            start_log();
            for (int i = 0; i < n; i++) begin
                q.push_back(8'($urandom));
                bus_write(A_TX, 4'b0001, 32'(q[i]));
            end
            for (int i = 0; i < n; i++) begin
                check_frame(q[i], div, (i == 0) ? 50 : 0, $sformatf("rnd%0d_f%0d", it, i));
            end
            check_idle(3, $sformatf("rnd%0d_idle", it));
            wait_idle($sformatf("rnd%0d_done", it));
        end

        // Reset mid-frame aborts the frame and discards queued bytes
        bus_write(A_DIV, 4'b0011, 50);
        bus_write(A_TX, 4'b0001, 32'h11);
        bus_write(A_TX, 4'b0001, 32'h22);
        bus_write(A_TX, 4'b0001, 32'h33);
        repeat (30) @(negedge clk);
        read_check("mr_div", A_DIV, 50);
        check("mr_in_start", 32'(txd), 0);
        #2 rst_n = 1'b0;
        #1;
        check("mr_txd", 32'(txd), 1);
        check("mr_irq", 32'(irq_tx_empty), 1);
        check("mr_douta", douta, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_check("mr_status", A_ST, st(0, 0, 1, 0, 0));
        read_check("mr_div_default", A_DIV, 433);
        start_log();
        check_idle(30, "mr_discarded");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
